global_bus_responder: RTL and testbench

- Bus-side end of the PE/bus protocol. Arbitrates bus_request from NUM_PE processing elements and drives a one-hot grant.
- Services one operation per grant from the shared bus signals: global-memory write/read, shared register-file write/read.
- Returns mem_ackBus, data_ReadyBus, memData, AmuxBus, BmuxBus and PCinBus to the granted PE's bus_interface.

---
 rtl/bus_pkg.sv | 48 ++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/global_bus_responder.sv | 208 ++++++++++++++++++++
 tb/tb_global_bus_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus-side responder of the PE/bus protocol.
package bus_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_MWR  = 3'd1,
    OP_MRD  = 3'd2,
    OP_RWR  = 3'd3,
    OP_RRD  = 3'd4
  } op_e;

  // Bus fields captured on the strobe cycle and held for the whole operation.
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_sel;
  } bus_fields_t;

  // Strobe priority: mem_write > mem_read > rd_write > read_en.
  function automatic op_e pick_op(input logic mw, input logic mr, input logic rw, input logic re);
    if (mw) return OP_MWR;
    if (mr) return OP_MRD;
    if (rw) return OP_RWR;
    if (re) return OP_RRD;
    return OP_NONE;
  endfunction

  function automatic logic multi_strobe(input logic [3:0] s);
    return (s & (s - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter  int unsigned NUM_PE = 4,
  localparam int unsigned PW     = $clog2(NUM_PE)
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_PE-1:0] gnt_c,
  output logic [PW-1:0]     win_c
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_c = '0;
    win_c = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      idx = (int'(ptr) + i) % NUM_PE;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt_c[idx] = 1'b1;
        win_c      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/global_bus_responder.sv
// Bus-side responder: arbitrates PE requests and services one memory or
// register-file operation per grant.
module global_bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned NUM_PE    = 4,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned TIMEOUT   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PE-1:0] bus_request,
  output logic [NUM_PE-1:0] grant,
  input  logic [XLEN-1:0]   mem_addressBus,
  input  logic [XLEN-1:0]   result_outBus,
  input  logic [XLEN-1:0]   PCoutBus,
  input  logic [REG_AW-1:0] rs1OutBus,
  input  logic [REG_AW-1:0] rs2OutBus,
  input  logic [REG_AW-1:0] rdOutBus,
  input  logic              reg_selectBus,
  input  logic              mem_readBus,
  input  logic              mem_writeBus,
  input  logic              rd_writeBus,
  input  logic              read_enBus,
  output logic [XLEN-1:0]   PCinBus,
  output logic [XLEN-1:0]   AmuxBus,
  output logic [XLEN-1:0]   BmuxBus,
  output logic [XLEN-1:0]   memData,
  output logic              mem_ackBus,
  output logic              data_ReadyBus,
  output logic              bus_error
);

  localparam int unsigned PW = $clog2(NUM_PE);
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned LW = $clog2(MEM_LAT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  bus_fields_t       fld_q, fld_d;
  logic [NUM_PE-1:0] grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [XLEN-1:0]   pcin_q, pcin_d;
  logic [XLEN-1:0]   amux_q, amux_d;
  logic [XLEN-1:0]   bmux_q, bmux_d;
  logic [XLEN-1:0]   mdata_q, mdata_d;
  logic              mack_q, mack_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;

  logic [XLEN-1:0]   regs_q [REG_COUNT];
  logic [XLEN-1:0]   mem_q  [MEM_DEPTH];

  logic [NUM_PE-1:0] arb_gnt_c;
  logic [PW-1:0]     arb_win_c;
  logic [3:0]        strobes_c;
  logic [AW-1:0]     mem_idx_c;
  logic              mem_we_c;
  logic              reg_we_c;
  logic              unused_addr_bits;

  rr_arbiter #(.NUM_PE(NUM_PE)) u_arb (
    .req   (bus_request),
    .ptr   (ptr_q),
    .gnt_c (arb_gnt_c),
    .win_c (arb_win_c)
  );

  assign strobes_c        = {mem_writeBus, mem_readBus, rd_writeBus, read_enBus};
  assign mem_idx_c        = fld_q.addr[AW+1:2];
  assign unused_addr_bits = ^{fld_q.addr[XLEN-1:AW+2], fld_q.addr[1:0]};

  // Next-state, datapath and output logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    fld_d    = fld_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    pcin_d   = pcin_q;
    amux_d   = amux_q;
    bmux_d   = bmux_q;
    mdata_d  = mdata_q;
    mack_d   = 1'b0;
    rdy_d    = 1'b0;
    err_d    = 1'b0;
    mem_we_c = 1'b0;
    reg_we_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (|bus_request) begin
          grant_d = arb_gnt_c;
          ptr_d   = (arb_win_c == PW'(NUM_PE - 1)) ? '0 : arb_win_c + PW'(1);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (|strobes_c) begin
          op_d          = pick_op(mem_writeBus, mem_readBus, rd_writeBus, read_enBus);
          err_d         = multi_strobe(strobes_c);
          fld_d.addr    = mem_addressBus;
          fld_d.wdata   = result_outBus;
          fld_d.pc      = PCoutBus;
          fld_d.rs1     = rs1OutBus;
          fld_d.rs2     = rs2OutBus;
          fld_d.rd      = rdOutBus;
          fld_d.reg_sel = reg_selectBus;
          cnt_d         = (op_d == OP_MRD) ? LW'(MEM_LAT - 1) : '0;
          state_d       = ST_BUSY;
        end else if (!(|(bus_request & grant_q))) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_BUSY: begin
        // Writes only ever span a single BUSY cycle.
        mem_we_c = (op_q == OP_MWR);
        reg_we_c = (op_q == OP_RWR) && (fld_q.rd != '0);
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          mack_d  = (op_q != OP_RRD);
          rdy_d   = (op_q == OP_RRD);
          pcin_d  = fld_q.pc + XLEN'(PC_STEP);
          if (op_q == OP_MRD) mdata_d = mem_q[mem_idx_c];
          if (op_q == OP_RRD) begin
            amux_d = regs_q[fld_q.rs1];
            bmux_d = fld_q.reg_sel ? regs_q[fld_q.rs2] : fld_q.wdata;
          end
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      ST_ACK: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      fld_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pcin_q  <= '0;
      amux_q  <= '0;
      bmux_q  <= '0;
      mdata_q <= '0;
      mack_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fld_q   <= fld_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pcin_q  <= pcin_d;
      amux_q  <= amux_d;
      bmux_q  <= bmux_d;
      mdata_q <= mdata_d;
      mack_q  <= mack_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      if (reg_we_c) regs_q[fld_q.rd] <= fld_q.wdata;
    end
  end

  // Global memory is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) mem_q[mem_idx_c] <= fld_q.wdata;
  end

  assign grant         = grant_q;
  assign PCinBus       = pcin_q;
  assign AmuxBus       = amux_q;
  assign BmuxBus       = bmux_q;
  assign memData       = mdata_q;
  assign mem_ackBus    = mack_q;
  assign data_ReadyBus = rdy_q;
  assign bus_error     = err_q;

endmodule

// File: tb/tb_global_bus_responder.sv
// Directed self-checking bench for global_bus_responder (default parameters).
module tb_global_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  bus_request;
  logic [3:0]  grant;
  logic [31:0] mem_addressBus, result_outBus, PCoutBus;
  logic [4:0]  rs1OutBus, rs2OutBus, rdOutBus;
  logic        reg_selectBus, mem_readBus, mem_writeBus, rd_writeBus, read_enBus;
  logic [31:0] PCinBus, AmuxBus, BmuxBus, memData;
  logic        mem_ackBus, data_ReadyBus, bus_error;

  int n_cmp = 0;
  int n_err = 0;

  global_bus_responder dut (
    .clk(clk), .reset(reset), .bus_request(bus_request), .grant(grant),
    .mem_addressBus(mem_addressBus), .result_outBus(result_outBus), .PCoutBus(PCoutBus),
    .rs1OutBus(rs1OutBus), .rs2OutBus(rs2OutBus), .rdOutBus(rdOutBus),
    .reg_selectBus(reg_selectBus), .mem_readBus(mem_readBus), .mem_writeBus(mem_writeBus),
    .rd_writeBus(rd_writeBus), .read_enBus(read_enBus), .PCinBus(PCinBus),
    .AmuxBus(AmuxBus), .BmuxBus(BmuxBus), .memData(memData), .mem_ackBus(mem_ackBus),
    .data_ReadyBus(data_ReadyBus), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic sel);
    mem_addressBus = addr; result_outBus = data; PCoutBus = pc;
    rs1OutBus = rs1; rs2OutBus = rs2; rdOutBus = rd; reg_selectBus = sel;
  endtask

  // Entered in an IDLE cycle; strb = {mem_write, mem_read, rd_write, read_en}.
  task automatic run_op(input string tag, input logic [3:0] req, input logic [3:0] exp_gnt,
                        input logic [3:0] strb, input int lat, input logic exp_mack,
                        input logic exp_rdy, input logic exp_err, input logic [31:0] exp_pcin);
    bus_request = req;
    tick();
    chk({tag, ":grant"}, 32'(grant), 32'(exp_gnt));
    {mem_writeBus, mem_readBus, rd_writeBus, read_enBus} = strb;
    tick();
    {mem_writeBus, mem_readBus, rd_writeBus, read_enBus} = 4'b0000;
    chk({tag, ":err"}, 32'(bus_error), 32'(exp_err));
    for (int k = 1; k <= lat; k++) begin
      chk({tag, ":early_ack"}, 32'({mem_ackBus, data_ReadyBus}), 32'(0));
      tick();
    end
    chk({tag, ":mem_ack"}, 32'(mem_ackBus), 32'(exp_mack));
    chk({tag, ":ready"}, 32'(data_ReadyBus), 32'(exp_rdy));
    chk({tag, ":grant_at_ack"}, 32'(grant), 32'(exp_gnt));
    chk({tag, ":pcin"}, PCinBus, exp_pcin);
    tick();
    chk({tag, ":grant_low"}, 32'(grant), 32'(0));
    chk({tag, ":ack_low"}, 32'({mem_ackBus, data_ReadyBus, bus_error}), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_request = '0;
    {mem_writeBus, mem_readBus, rd_writeBus, read_enBus} = 4'b0000;
    set_fields(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst:grant", 32'(grant), 32'(0));
    chk("rst:pcin", PCinBus, 32'h0);
    chk("rst:amux", AmuxBus, 32'h0);
    chk("rst:bmux", BmuxBus, 32'h0);
    chk("rst:memdata", memData, 32'h0);
    chk("rst:acks", 32'({mem_ackBus, data_ReadyBus, bus_error}), 32'(0));
    reset = 1'b0;

    // Round robin with all four PEs requesting, each writing a register.
    for (int i = 0; i < 4; i++) begin
      set_fields(32'h0, 32'hA000_0000 | 32'(i + 1), 32'(32'h100 * (i + 1)), 5'd0, 5'd0,
                 5'(i + 1), 1'b0);
      run_op("rr", 4'b1111, 4'(4'b0001 << i), 4'b0010, 1, 1'b1, 1'b0, 1'b0,
             32'(32'h100 * (i + 1) + 4));
    end
    set_fields(32'h0, 32'h0, 32'h500, 5'd1, 5'd4, 5'd0, 1'b1);
    run_op("rr5", 4'b1111, 4'b0001, 4'b0001, 1, 1'b0, 1'b1, 1'b0, 32'h504);
    chk("rr5:amux", AmuxBus, 32'hA000_0001);
    chk("rr5:bmux", BmuxBus, 32'hA000_0004);

    // Memory write/read, including an aliased address of the same word.
    set_fields(32'hAABB_CCDD, 32'h1234_5678, 32'h1000, 5'd0, 5'd0, 5'd0, 1'b0);
    run_op("mwr", 4'b0001, 4'b0001, 4'b1000, 1, 1'b1, 1'b0, 1'b0, 32'h1004);
    run_op("mrd", 4'b0001, 4'b0001, 4'b0100, 2, 1'b1, 1'b0, 1'b0, 32'h1004);
    chk("mrd:memdata", memData, 32'h1234_5678);
    set_fields(32'hFFFF_0CDC, 32'hDEAD_BEEF, 32'h1010, 5'd0, 5'd0, 5'd0, 1'b0);
    run_op("mwr_alias", 4'b0001, 4'b0001, 4'b1000, 1, 1'b1, 1'b0, 1'b0, 32'h1014);
    set_fields(32'hAABB_CCDD, 32'h0, 32'h1020, 5'd0, 5'd0, 5'd0, 1'b0);
    run_op("mrd_alias", 4'b0001, 4'b0001, 4'b0100, 2, 1'b1, 1'b0, 1'b0, 32'h1024);
    chk("mrd_alias:memdata", memData, 32'hDEAD_BEEF);

    // Register write and both B operand sources.
    set_fields(32'h0, 32'hFACE_CAFE, 32'h2000, 5'd0, 5'd0, 5'd10, 1'b0);
    run_op("rwr10", 4'b0001, 4'b0001, 4'b0010, 1, 1'b1, 1'b0, 1'b0, 32'h2004);
    set_fields(32'h0, 32'h0, 32'h2010, 5'd10, 5'd0, 5'd0, 1'b1);
    run_op("rrd_sel1", 4'b0001, 4'b0001, 4'b0001, 1, 1'b0, 1'b1, 1'b0, 32'h2014);
    chk("rrd_sel1:amux", AmuxBus, 32'hFACE_CAFE);
    chk("rrd_sel1:bmux", BmuxBus, 32'h0);
    set_fields(32'h0, 32'h55, 32'h2020, 5'd10, 5'd0, 5'd0, 1'b0);
    run_op("rrd_sel0", 4'b0001, 4'b0001, 4'b0001, 1, 1'b0, 1'b1, 1'b0, 32'h2024);
    chk("rrd_sel0:amux", AmuxBus, 32'hFACE_CAFE);
    chk("rrd_sel0:bmux", BmuxBus, 32'h55);

    // Multi-strobe: only the write is serviced, memData is not refreshed.
    set_fields(32'h40, 32'h0BAD_F00D, 32'h3000, 5'd0, 5'd0, 5'd0, 1'b0);
    run_op("multi", 4'b0001, 4'b0001, 4'b1100, 1, 1'b1, 1'b0, 1'b1, 32'h3004);
    chk("multi:memdata_held", memData, 32'hDEAD_BEEF);
    set_fields(32'h40, 32'h0, 32'h3010, 5'd0, 5'd0, 5'd0, 1'b0);
    run_op("multi_rd", 4'b0001, 4'b0001, 4'b0100, 2, 1'b1, 1'b0, 1'b0, 32'h3014);
    chk("multi_rd:memdata", memData, 32'h0BAD_F00D);

    // x0 stays zero.
    set_fields(32'h0, 32'hFFFF_FFFF, 32'h4000, 5'd0, 5'd0, 5'd0, 1'b0);
    run_op("x0_wr", 4'b0001, 4'b0001, 4'b0010, 1, 1'b1, 1'b0, 1'b0, 32'h4004);
    set_fields(32'h0, 32'h0, 32'h4010, 5'd0, 5'd0, 5'd0, 1'b1);
    run_op("x0_rd", 4'b0001, 4'b0001, 4'b0001, 1, 1'b0, 1'b1, 1'b0, 32'h4014);
    chk("x0_rd:amux", AmuxBus, 32'h0);
    chk("x0_rd:bmux", BmuxBus, 32'h0);

    // PC wrap.
    set_fields(32'h0, 32'h77, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd5, 1'b0);
    run_op("pcwrap", 4'b0001, 4'b0001, 4'b0010, 1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Timeout: eight idle grant cycles, then error pulse and grant drop.
    bus_request = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("tmo:grant_held", 32'(grant), 32'(4'b0001));
      chk("tmo:no_err", 32'(bus_error), 32'(0));
    end
    tick();
    bus_request = 4'b0000;
    chk("tmo:err", 32'(bus_error), 32'(1));
    chk("tmo:grant_low", 32'(grant), 32'(0));
    chk("tmo:no_ack", 32'({mem_ackBus, data_ReadyBus}), 32'(0));
    tick();
    chk("tmo:err_once", 32'(bus_error), 32'(0));
    chk("tmo:idle", 32'(grant), 32'(0));

    // Reset in the middle of a mem_read.
    set_fields(32'h40, 32'h0, 32'h200, 5'd0, 5'd0, 5'd0, 1'b0);
    run_op("pre_rst", 4'b0001, 4'b0001, 4'b0100, 2, 1'b1, 1'b0, 1'b0, 32'h204);
    chk("pre_rst:memdata", memData, 32'h0BAD_F00D);
    bus_request = 4'b0001;
    tick();
    chk("rstmid:grant", 32'(grant), 32'(4'b0001));
    mem_readBus = 1'b1;
    tick();
    mem_readBus = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_request = 4'b0000;
    chk("rstmid:grant0", 32'(grant), 32'(0));
    chk("rstmid:acks0", 32'({mem_ackBus, data_ReadyBus, bus_error}), 32'(0));
    chk("rstmid:memdata0", memData, 32'h0);
    chk("rstmid:pcin0", PCinBus, 32'h0);
    tick();
    chk("rstmid:no_late_ack", 32'({mem_ackBus, data_ReadyBus}), 32'(0));
    chk("rstmid:still_idle", 32'(grant), 32'(0));

    // Register file is cleared by reset.
    set_fields(32'h0, 32'h0, 32'h300, 5'd10, 5'd10, 5'd0, 1'b1);
    run_op("post_rst", 4'b0001, 4'b0001, 4'b0001, 1, 1'b0, 1'b1, 1'b0, 32'h304);
    chk("post_rst:amux", AmuxBus, 32'h0);
    chk("post_rst:bmux", BmuxBus, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
